// File: rtl/alu_rs_pkg.sv
// Shared sizing and operand-capture helper for the ALU reservation station.
// The broadcast snoop is shared by dispatch-cycle bypass and per-entry wakeup.
package alu_rs_pkg;

  localparam int RS_SIZE_DEF       = 8;
  localparam int RS_TYPE_WIDTH_DEF = 6;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int RS_IDX_W_DEF = idx_width(RS_SIZE_DEF);

  typedef struct packed {
    logic        pending;
    logic [31:0] value;
  } opnd_t;

  // cdb0 is checked first so it wins when both buses carry the same tag.
  function automatic opnd_t snoop(
    input logic        pending,
    input logic [31:0] tag,
    input logic [31:0] value,
    input logic        b0_en,
    input logic [31:0] b0_tag,
    input logic [31:0] b0_val,
    input logic        b1_en,
    input logic [31:0] b1_tag,
    input logic [31:0] b1_val
  );
    opnd_t r;
    r.pending = pending;
    r.value   = value;
    if (pending) begin
      if (b0_en && (b0_tag == tag)) begin
        r.pending = 1'b0;
        r.value   = b0_val;
      end else if (b1_en && (b1_tag == tag)) begin
        r.pending = 1'b0;
        r.value   = b1_val;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-set-bit priority encoder with a found flag.
module rs_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch into the lowest free slot, wake operands
// from two result buses, issue the lowest ready entry to the ALU each cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE       = RS_SIZE_DEF,
  parameter int RS_TYPE_WIDTH = RS_TYPE_WIDTH_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush,
  input  logic                     dispatch_en,
  input  logic [RS_TYPE_WIDTH-1:0] dispatch_type,
  input  logic [31:0]              dispatch_rob_id,
  input  logic [31:0]              dispatch_imm,
  input  logic [31:0]              dispatch_vj,
  input  logic [31:0]              dispatch_vk,
  input  logic                     dispatch_qj_valid,
  input  logic                     dispatch_qk_valid,
  input  logic [31:0]              dispatch_qj,
  input  logic [31:0]              dispatch_qk,
  output logic                     full,
  input  logic                     cdb0_en,
  input  logic [31:0]              cdb0_rob_id,
  input  logic [31:0]              cdb0_value,
  input  logic                     cdb1_en,
  input  logic [31:0]              cdb1_rob_id,
  input  logic [31:0]              cdb1_value,
  output logic                     alu_en,
  output logic [31:0]              alu_rob_id,
  output logic [31:0]              alu_data_j,
  output logic [31:0]              alu_data_k,
  output logic [31:0]              alu_imm,
  output logic [RS_TYPE_WIDTH-1:0] alu_type
);

  localparam int IDX_W = idx_width(RS_SIZE);

  logic [RS_SIZE-1:0]       busy;
  logic [RS_SIZE-1:0]       qj_valid;
  logic [RS_SIZE-1:0]       qk_valid;
  logic [RS_TYPE_WIDTH-1:0] ent_type [RS_SIZE];
  logic [31:0]              ent_rob  [RS_SIZE];
  logic [31:0]              ent_imm  [RS_SIZE];
  logic [31:0]              vj       [RS_SIZE];
  logic [31:0]              vk       [RS_SIZE];
  logic [31:0]              qj       [RS_SIZE];
  logic [31:0]              qk       [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   rdy_idx;
  logic               free_found;
  logic               rdy_found;
  opnd_t              wake_j [RS_SIZE];
  opnd_t              wake_k [RS_SIZE];
  opnd_t              disp_j;
  opnd_t              disp_k;

  assign full = &busy;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i]  = busy[i] & ~qj_valid[i] & ~qk_valid[i];
      wake_j[i] = snoop(qj_valid[i], qj[i], vj[i], cdb0_en, cdb0_rob_id, cdb0_value,
                        cdb1_en, cdb1_rob_id, cdb1_value);
      wake_k[i] = snoop(qk_valid[i], qk[i], vk[i], cdb0_en, cdb0_rob_id, cdb0_value,
                        cdb1_en, cdb1_rob_id, cdb1_value);
    end
    disp_j = snoop(dispatch_qj_valid, dispatch_qj, dispatch_vj, cdb0_en, cdb0_rob_id,
                   cdb0_value, cdb1_en, cdb1_rob_id, cdb1_value);
    disp_k = snoop(dispatch_qk_valid, dispatch_qk, dispatch_vk, cdb0_en, cdb0_rob_id,
                   cdb0_value, cdb1_en, cdb1_rob_id, cdb1_value);
  end

  rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_pick_free (
    .req   (~busy),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_pick_ready (
    .req   (ready),
    .idx   (rdy_idx),
    .found (rdy_found)
  );

  // Wakeup only touches busy entries and dispatch only a free one, so the
  // three writers below never target the same entry in one cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy       <= '0;
      qj_valid   <= '0;
      qk_valid   <= '0;
      alu_en     <= 1'b0;
      alu_rob_id <= '0;
      alu_data_j <= '0;
      alu_data_k <= '0;
      alu_imm    <= '0;
      alu_type   <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        busy       <= '0;
        alu_en     <= 1'b0;
        alu_rob_id <= '0;
        alu_data_j <= '0;
        alu_data_k <= '0;
        alu_imm    <= '0;
        alu_type   <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            qj_valid[i] <= wake_j[i].pending;
            vj[i]       <= wake_j[i].value;
            qk_valid[i] <= wake_k[i].pending;
            vk[i]       <= wake_k[i].value;
          end
        end
        if (rdy_found) begin
          alu_en         <= 1'b1;
          alu_rob_id     <= ent_rob[rdy_idx];
          alu_data_j     <= vj[rdy_idx];
          alu_data_k     <= vk[rdy_idx];
          alu_imm        <= ent_imm[rdy_idx];
          alu_type       <= ent_type[rdy_idx];
          busy[rdy_idx]  <= 1'b0;
        end else begin
          alu_en     <= 1'b0;
          alu_rob_id <= '0;
          alu_data_j <= '0;
          alu_data_k <= '0;
          alu_imm    <= '0;
          alu_type   <= '0;
        end
        if (dispatch_en && free_found) begin
          busy[free_idx]     <= 1'b1;
          ent_type[free_idx] <= dispatch_type;
          ent_rob[free_idx]  <= dispatch_rob_id;
          ent_imm[free_idx]  <= dispatch_imm;
          qj[free_idx]       <= dispatch_qj;
          qk[free_idx]       <= dispatch_qk;
          qj_valid[free_idx] <= disp_j.pending;
          vj[free_idx]       <= disp_j.value;
          qk_valid[free_idx] <= disp_k.pending;
          vk[free_idx]       <= disp_k.value;
        end
      end
    end
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of entries (power of two, 2..16).
REQ-002 SHALL have parameter RS_TYPE_WIDTH, default 6, width of the operation type code.
REQ-003 SHALL have port clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rdy_in  input  1  global enable; when low, all state and outputs hold.
REQ-006 SHALL have port flush  input  1  mispredict flush, effective only with rdy_in high.
REQ-007 SHALL have dispatch inputs: dispatch_en 1; dispatch_type RS_TYPE_WIDTH; dispatch_rob_id 32; dispatch_imm 32; dispatch_vj, dispatch_vk 32 operand values; dispatch_qj_valid, dispatch_qk_valid 1 (operand pending); dispatch_qj, dispatch_qk 32 producer ROB ids.
REQ-008 SHALL have port full  output  1  no free entry; combinational from registered state.
REQ-009 SHALL have broadcast inputs cdb0_en 1, cdb0_rob_id 32, cdb0_value 32 (ALU result bus) and cdb1_en, cdb1_rob_id, cdb1_value (load/store bus), same widths.
REQ-010 SHALL have registered issue outputs alu_en 1, alu_rob_id 32, alu_data_j 32, alu_data_k 32, alu_imm 32, alu_type RS_TYPE_WIDTH, driving the ALU directly.

Function
REQ-011 Each entry SHALL hold busy, type, rob_id, imm, vj, vk, qj_valid, qj, qk_valid, qk.
REQ-012 Dispatch: when rdy_in and dispatch_en and not full, SHALL write the lowest-index non-busy entry and set busy.
REQ-013 dispatch_en while full SHALL be ignored; no entry altered.
REQ-014 Unused operands (immediate forms, type[4] set, for k) SHALL be dispatched with q*_valid=0; the block does not decode type for readiness.
REQ-015 Wakeup: each cycle with rdy_in, for every busy entry and each cdbN_en, a pending operand whose tag equals cdbN_rob_id SHALL capture cdbN_value and clear its q*_valid.
REQ-016 Dispatch-cycle bypass: a dispatched operand whose tag matches an active broadcast in the same cycle SHALL be stored as ready with the broadcast value.
REQ-017 If both buses match the same tag, cdb0 SHALL win.
REQ-018 An entry is ready when busy and both q*_valid are 0 in registered state; wakeup in cycle N makes it eligible in cycle N+1, never N.
REQ-019 Select: each rdy_in cycle, the lowest-index ready entry SHALL be issued: its fields copied to alu_* at the clock edge, alu_en set to 1, busy cleared at the same edge.
REQ-020 At most one issue per cycle; with no ready entry, alu_en SHALL be 0 and other alu_* SHALL be 0 next cycle.
REQ-021 Latency: dispatch with both operands ready in cycle N -> alu_en high in cycle N+1 at earliest; alu_en is a one-cycle pulse per issued entry.
REQ-022 An entry freed by issue in cycle N SHALL be reusable by dispatch from cycle N+1 (full deasserts at N+1).
REQ-023 Dispatch and issue in the same cycle SHALL both occur; a freshly dispatched entry is never issued in its dispatch cycle.
REQ-024 rdy_in low SHALL freeze everything, including ignoring dispatch and broadcasts that cycle.
REQ-025 flush with rdy_in SHALL clear all busy bits and drive all alu_* outputs to 0 next cycle; concurrent dispatch, wakeup and issue are discarded.

Reset
REQ-026 rst_in high at a clock edge SHALL clear all busy and q*_valid bits and set every alu_* output to 0, regardless of rdy_in.
REQ-027 After reset full SHALL be 0; reset mid-operation discards all entries with no issue.
REQ-028 Entry payload fields need not be reset.

Structure
REQ-029 RS_TYPE_WIDTH, RS_SIZE and derived index width SHALL live in the shared parameters file.
REQ-030 One sub-module, rs_pick (lowest-set-bit priority encoder with found flag), SHALL be instantiated twice: free-slot and ready-entry selection.

Verification
REQ-031 Reset then dispatch rob 3, type ADD, vj=5, vk=7, both ready -> next cycle alu_en=1, rob_id=3, data_j=5, data_k=7; following cycle alu_en=0.
REQ-032 Dispatch rob 4 with qj=2 pending; cdb0 rob 2 value 0x10 two cycles later -> issue one cycle after broadcast with data_j=0x10.
REQ-033 Dispatch with qk=9 while cdb1 broadcasts rob 9 value 0xAB same cycle -> entry issues next cycle with data_k=0xAB.
REQ-034 Fill 8 entries all pending -> full=1; 9th dispatch ignored; wake entry 5 -> issues, full=0 exactly next cycle.
REQ-035 Three entries pending; broadcast waking entries 6 and 2 together -> entry 2 issues first, entry 6 next cycle.
REQ-036 Flush with 4 busy entries and rdy_in=1 -> next cycle full=0, alu_en=0; later broadcasts cause no issue; flush with rdy_in=0 -> no effect.
